egress_arbiter: RTL and testbench

EGRESS_ARBITER -- requirements
Module: egress_arbiter

---
 rtl/egress_arbiter.sv | 102 ++++++++++
 tb/tb_egress_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_arbiter.sv
// Merges two FIFOs into one egress stream: D0 preferred, D1 granted once D0 has had
// max_streak consecutive grants; popped words come out on a registered two-stage path.
//
// state  | meaning
// IDLE   | both FIFOs empty, nothing popped
// ACTIVE | one pop per cycle while downstream has room
// PAUSE  | downstream almost full, pops held off

module egress_arbiter #(
    parameter int data_width = 6,
    parameter int max_streak = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  D0_empty,
    input  logic                  D1_empty,
    input  logic [data_width-1:0] data_in_D0,
    input  logic [data_width-1:0] data_in_D1,
    input  logic                  out_almost_full,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            state_out,
    output logic [4:0]            cnt_D0,
    output logic [4:0]            cnt_D1
);
    localparam int sw = $clog2(max_streak + 1);
    localparam logic [sw-1:0] streak_max = sw'(max_streak);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        PAUSE  = 2'b10
    } state_t;

    state_t        state, state_next;
    logic [sw-1:0] streak, streak_next;
    logic          grant_d0, grant_d1, pop_ok;
    logic          pend_valid, pend_d1;

    always_comb begin
        state_next  = state;
        streak_next = streak;
        D0_pop      = 1'b0;
        D1_pop      = 1'b0;
        grant_d0    = !D0_empty && !((streak == streak_max) && !D1_empty);
        grant_d1    = !grant_d0 && !D1_empty;
        pop_ok      = (state == ACTIVE) && !out_almost_full && !reset;

        case (state)
            IDLE:    if (!D0_empty || !D1_empty) state_next = ACTIVE;
            ACTIVE:  if (out_almost_full)        state_next = PAUSE;
                     else if (D0_empty && D1_empty) state_next = IDLE;
            PAUSE:   if (!out_almost_full)       state_next = ACTIVE;
            default: state_next = IDLE;
        endcase

        if (pop_ok) begin
            D0_pop = grant_d0;
            D1_pop = grant_d1;
        end

        // streak only measures how long D1 has been kept waiting
        if (D1_empty || D1_pop)
            streak_next = '0;
        else if (D0_pop && (streak != streak_max))
            streak_next = streak + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            streak     <= '0;
            pend_valid <= 1'b0;
            pend_d1    <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            cnt_D0     <= '0;
            cnt_D1     <= '0;
        end else begin
            state      <= state_next;
            streak     <= streak_next;
            pend_valid <= D0_pop | D1_pop;
            pend_d1    <= D1_pop;
            valid_out  <= pend_valid;
            // FIFO read data is on its port the cycle after the pop
            if (pend_valid) begin
                if (pend_d1) begin
                    data_out <= data_in_D1;
                    cnt_D1   <= cnt_D1 + 5'd1;
                end else begin
                    data_out <= data_in_D0;
                    cnt_D0   <= cnt_D0 + 5'd1;
                end
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_egress_arbiter.sv
// Bench for egress_arbiter: queue-backed FIFO models, directed scenarios and a
// randomized run checked against a transaction-level reference model.

module tb_egress_arbiter;
    localparam int W    = 6;
    localparam int MAXS = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         D0_empty = 1'b1;
    logic         D1_empty = 1'b1;
    logic [W-1:0] data_in_D0 = '0;
    logic [W-1:0] data_in_D1 = '0;
    logic         out_almost_full = 1'b0;
    logic         D0_pop, D1_pop, valid_out;
    logic [W-1:0] data_out;
    logic [1:0]   state_out;
    logic [4:0]   cnt_D0, cnt_D1;

    int total = 0;
    int bad   = 0;

    egress_arbiter #(.data_width(W), .max_streak(MAXS)) dut (
        .clk(clk), .reset(reset), .D0_empty(D0_empty), .D1_empty(D1_empty),
        .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
        .out_almost_full(out_almost_full), .D0_pop(D0_pop), .D1_pop(D1_pop),
        .data_out(data_out), .valid_out(valid_out), .state_out(state_out),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1)
    );

    always #5 clk = ~clk;

    // FIFO models: stimulus appends to p0/p1, words become visible one edge later
    logic [W-1:0] p0[$], p1[$], q0[$], q1[$];
    int   take0 = 0, take1 = 0;
    logic flush = 1'b0;

    always @(posedge clk) begin
        if (D0_pop && q0.size() > 0) begin
            data_in_D0 <= q0[0];
            q0.delete(0);
        end
        if (D1_pop && q1.size() > 0) begin
            data_in_D1 <= q1[0];
            q1.delete(0);
        end
        while (take0 < p0.size()) begin q0.push_back(p0[take0]); take0++; end
        while (take1 < p1.size()) begin q1.push_back(p1[take1]); take1++; end
        if (flush) begin
            q0.delete();
            q1.delete();
        end
        D0_empty <= (q0.size() == 0);
        D1_empty <= (q1.size() == 0);
    end

    // Reference model: grant/state rules per cycle, words travel as transactions
    int           m_mode = 0, m_run = 0, m_cnt0 = 0, m_cnt1 = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         fl_v = 1'b0, fl_src = 1'b0;
    logic [W-1:0] fl_d = '0;
    logic         exp_pop0 = 1'b0, exp_pop1 = 1'b0, exp_valid = 1'b0;
    logic [W-1:0] exp_data = '0;
    int           exp_cnt0 = 0, exp_cnt1 = 0, exp_state = 0;

    always @(negedge clk) begin
        exp_valid = m_valid;
        exp_data  = m_data;
        exp_cnt0  = m_cnt0;
        exp_cnt1  = m_cnt1;
        exp_state = m_mode;
        exp_pop0  = 1'b0;
        exp_pop1  = 1'b0;
        if (m_mode == 1 && !out_almost_full && !reset) begin
            if (!D0_empty && (m_run < MAXS || D1_empty)) exp_pop0 = 1'b1;
            else if (!D1_empty)                           exp_pop1 = 1'b1;
        end
        if (reset) begin
            m_mode = 0; m_run = 0; m_cnt0 = 0; m_cnt1 = 0;
            m_valid = 1'b0; m_data = '0; fl_v = 1'b0;
        end else begin
            m_valid = fl_v;
            if (fl_v) begin
                m_data = fl_d;
                if (fl_src) m_cnt1 = (m_cnt1 + 1) % 32;
                else        m_cnt0 = (m_cnt0 + 1) % 32;
            end
            fl_v   = exp_pop0 | exp_pop1;
            fl_src = exp_pop1;
            if (exp_pop1)      fl_d = q1[0];
            else if (exp_pop0) fl_d = q0[0];
            if (D1_empty || exp_pop1)         m_run = 0;
            else if (exp_pop0 && m_run < MAXS) m_run++;
            case (m_mode)
                0: if (!D0_empty || !D1_empty) m_mode = 1;
                1: if (out_almost_full) m_mode = 2;
                   else if (D0_empty && D1_empty) m_mode = 0;
                default: if (!out_almost_full) m_mode = 1;
            endcase
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        p0.push_back(6'h3f);
        @(posedge clk); #1;
        @(negedge clk); #1;
        total++; if (D0_pop !== 1'b0) begin bad++; $display("FAIL reset_d0_pop got=%b want=0", D0_pop); end
        total++; if (D1_pop !== 1'b0) begin bad++; $display("FAIL reset_d1_pop got=%b want=0", D1_pop); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%0h want=0", data_out); end
        total++; if (state_out !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", state_out); end
        total++; if (cnt_D0 !== 5'd0) begin bad++; $display("FAIL reset_cnt0 got=%0d want=0", cnt_D0); end
        total++; if (cnt_D1 !== 5'd0) begin bad++; $display("FAIL reset_cnt1 got=%0d want=0", cnt_D1); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_d0_only();
        int pc[16];
        int vc[16];
        logic [W-1:0] vd[16];
        int np = 0, nv = 0;
        for (int i = 1; i <= 3; i++) p0.push_back(W'(i));
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); #1;
            if (D0_pop) begin
                total++;
                if (state_out !== 2'b01) begin bad++; $display("FAIL d0_pop_state got=%b want=01", state_out); end
                if (np < 16) pc[np] = c;
                np++;
            end
            if (valid_out) begin
                if (nv < 16) begin vc[nv] = c; vd[nv] = data_out; end
                nv++;
            end
            @(posedge clk); #1;
        end
        total++; if (np != 3) begin bad++; $display("FAIL d0_pop_count got=%0d want=3", np); end
        total++; if (pc[2] != pc[0] + 2) begin bad++; $display("FAIL d0_pop_consecutive got=%0d want=%0d", pc[2], pc[0] + 2); end
        total++; if (nv != 3) begin bad++; $display("FAIL d0_valid_count got=%0d want=3", nv); end
        total++; if (vc[0] != pc[0] + 2) begin bad++; $display("FAIL d0_latency got=%0d want=%0d", vc[0], pc[0] + 2); end
        total++; if (vc[2] != vc[0] + 2) begin bad++; $display("FAIL d0_valid_consecutive got=%0d want=%0d", vc[2], vc[0] + 2); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (vd[i] !== W'(i + 1)) begin bad++; $display("FAIL d0_word%0d got=%0h want=%0h", i, vd[i], i + 1); end
        end
        total++; if (cnt_D0 !== 5'd3) begin bad++; $display("FAIL d0_cnt0 got=%0d want=3", cnt_D0); end
        total++; if (cnt_D1 !== 5'd0) begin bad++; $display("FAIL d0_cnt1 got=%0d want=0", cnt_D1); end
        total++; if (state_out !== 2'b00) begin bad++; $display("FAIL d0_end_state got=%b want=00", state_out); end
    endtask

    task automatic test_streak();
        logic [W-1:0] want[8];
        logic [W-1:0] vd[8];
        logic [7:0] ord;
        int n = 0, nv = 0;
        want = '{6'd1, 6'd2, 6'd3, 6'd4, 6'h21, 6'd5, 6'd6, 6'h22};
        ord = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) p0.push_back(W'(i));
        p1.push_back(6'h21);
        p1.push_back(6'h22);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk); #1;
            if (D0_pop || D1_pop) begin
                if (n < 8) ord[n] = D1_pop;
                n++;
            end
            if (valid_out) begin
                if (nv < 8) vd[nv] = data_out;
                nv++;
            end
            @(posedge clk); #1;
        end
        total++; if (n != 8) begin bad++; $display("FAIL streak_pops got=%0d want=8", n); end
        total++; if (ord !== 8'b1001_0000) begin bad++; $display("FAIL streak_order got=%b want=10010000", ord); end
        total++; if (nv != 8) begin bad++; $display("FAIL streak_valid_count got=%0d want=8", nv); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (vd[i] !== want[i]) begin bad++; $display("FAIL streak_word%0d got=%0h want=%0h", i, vd[i], want[i]); end
        end
        total++; if (cnt_D0 !== 5'd6) begin bad++; $display("FAIL streak_cnt0 got=%0d want=6", cnt_D0); end
        total++; if (cnt_D1 !== 5'd2) begin bad++; $display("FAIL streak_cnt1 got=%0d want=2", cnt_D1); end
    endtask

    task automatic test_backpressure();
        int c0 = -1, a = 1000, pops_af = 0, tail = 0, nv = 0, order_bad = 0;
        logic [1:0] pause_state = 2'b11;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) p0.push_back(W'(i));
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            out_almost_full = (c0 >= 0) && (c >= a) && (c < a + 3);
            @(negedge clk); #1;
            if (c0 < 0 && D0_pop) begin c0 = c; a = c + 3; end
            if (c >= a && c < a + 3 && (D0_pop || D1_pop)) pops_af++;
            if (c >= a && c <= a + 4 && valid_out) tail++;
            if (c == a + 1) pause_state = state_out;
            if (valid_out) begin
                if (data_out !== W'(nv + 1)) order_bad++;
                nv++;
            end
        end
        out_almost_full = 1'b0;
        total++; if (c0 < 0) begin bad++; $display("FAIL bp_first_pop got=none want=seen"); end
        total++; if (pops_af != 0) begin bad++; $display("FAIL bp_pops_while_full got=%0d want=0", pops_af); end
        total++; if (tail > 2) begin bad++; $display("FAIL bp_overshoot got=%0d want<=2", tail); end
        total++; if (pause_state !== 2'b10) begin bad++; $display("FAIL bp_pause_state got=%b want=10", pause_state); end
        total++; if (nv != 10) begin bad++; $display("FAIL bp_words got=%0d want=10", nv); end
        total++; if (order_bad != 0) begin bad++; $display("FAIL bp_order got=%0d want=0", order_bad); end
        total++; if (cnt_D0 !== 5'd10) begin bad++; $display("FAIL bp_cnt0 got=%0d want=10", cnt_D0); end
        total++; if (state_out !== 2'b00) begin bad++; $display("FAIL bp_end_state got=%b want=00", state_out); end
    endtask

    task automatic test_reset_mid();
        int r = -1, run = 0, late = 0;
        for (int i = 1; i <= 8; i++) p0.push_back(W'(i));
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (r < 0 && run >= 2) begin
                r = c; reset = 1'b1; flush = 1'b1;
            end else if (r >= 0 && c == r + 1) begin
                reset = 1'b0; flush = 1'b0;
            end
            @(negedge clk); #1;
            run = (D0_pop || D1_pop) ? run + 1 : 0;
            if (r >= 0 && c == r) begin
                total++;
                if (D0_pop !== 1'b0) begin bad++; $display("FAIL mid_pop_in_reset got=%b want=0", D0_pop); end
            end
            if (r >= 0 && c == r + 1) begin
                total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", valid_out); end
                total++; if (data_out !== '0) begin bad++; $display("FAIL mid_data got=%0h want=0", data_out); end
                total++; if (cnt_D0 !== 5'd0) begin bad++; $display("FAIL mid_cnt0 got=%0d want=0", cnt_D0); end
                total++; if (cnt_D1 !== 5'd0) begin bad++; $display("FAIL mid_cnt1 got=%0d want=0", cnt_D1); end
                total++; if (state_out !== 2'b00) begin bad++; $display("FAIL mid_state got=%b want=00", state_out); end
            end
            if (r >= 0 && c > r && valid_out) late++;
            if (r >= 0 && c >= r + 6) break;
        end
        reset = 1'b0; flush = 1'b0;
        total++; if (r < 0) begin bad++; $display("FAIL mid_no_stream got=none want=2 pops in flight"); end
        total++; if (late != 0) begin bad++; $display("FAIL mid_late_valid got=%0d want=0", late); end
    endtask

    task automatic test_wrap();
        int viol = 0, nv = 0;
        for (int i = 0; i < 33; i++) p1.push_back(W'(i));
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); #1;
            if (D0_pop && D1_pop)   viol++;
            if (D0_pop && D0_empty) viol++;
            if (D1_pop && D1_empty) viol++;
            if (valid_out) nv++;
            @(posedge clk); #1;
        end
        total++; if (nv != 33) begin bad++; $display("FAIL wrap_words got=%0d want=33", nv); end
        total++; if (viol != 0) begin bad++; $display("FAIL wrap_pop_violations got=%0d want=0", viol); end
        total++; if (cnt_D1 !== 5'd1) begin bad++; $display("FAIL wrap_cnt1 got=%0d want=1", cnt_D1); end
        total++; if (cnt_D0 !== 5'd0) begin bad++; $display("FAIL wrap_cnt0 got=%0d want=0", cnt_D0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (c < 520) begin
                if ($urandom_range(0, 2) == 0) p0.push_back(W'($urandom));
                if ($urandom_range(0, 3) == 0) p1.push_back(W'($urandom));
                out_almost_full = ($urandom_range(0, 4) == 0);
                reset = ($urandom_range(0, 149) == 0);
            end else begin
                out_almost_full = 1'b0;
                reset = 1'b0;
            end
            @(negedge clk); #1;
            total++; if (D0_pop !== exp_pop0) begin bad++; $display("FAIL rnd_pop0 cyc=%0d got=%b want=%b", c, D0_pop, exp_pop0); end
            total++; if (D1_pop !== exp_pop1) begin bad++; $display("FAIL rnd_pop1 cyc=%0d got=%b want=%b", c, D1_pop, exp_pop1); end
            total++; if (valid_out !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, valid_out, exp_valid); end
            total++; if (data_out !== exp_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%0h want=%0h", c, data_out, exp_data); end
            total++; if (cnt_D0 !== 5'(exp_cnt0)) begin bad++; $display("FAIL rnd_cnt0 cyc=%0d got=%0d want=%0d", c, cnt_D0, exp_cnt0); end
            total++; if (cnt_D1 !== 5'(exp_cnt1)) begin bad++; $display("FAIL rnd_cnt1 cyc=%0d got=%0d want=%0d", c, cnt_D1, exp_cnt1); end
            total++; if (state_out !== 2'(exp_state)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%b want=%0d", c, state_out, exp_state); end
        end
    endtask

    initial begin
        test_reset();
        test_d0_only();
        test_streak();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
